// File: rtl/img_ycbcr_pkg.sv
// Shared constants and types for the YCbCr -> RGB conversion slice.
package img_ycbcr_pkg;

   // Q8 BT.601 full-range inverse coefficients
   localparam int unsigned COEF_R_CR  = 359;
   localparam int unsigned COEF_G_CB  = 88;
   localparam int unsigned COEF_G_CR  = 183;
   localparam int unsigned COEF_B_CB  = 454;
   localparam int unsigned COEF_SHIFT = 8;
   localparam int unsigned ROUND_Q8   = 128;

   // Chroma offset for 8-bit components; other widths use offset_f()
   localparam int unsigned OFFSET_8B  = 128;

   localparam int unsigned PIPE_LATENCY = 3;
   localparam int unsigned CNT_W        = 16;

   // Sticky status flag positions
   localparam int unsigned ERR_W        = 4;
   localparam int unsigned ERR_HS_NO_VS = 0;
   localparam int unsigned ERR_VS_NO_FS = 1;
   localparam int unsigned ERR_LINE_LEN = 2;
   localparam int unsigned ERR_CLAMP    = 3;

   // Sync strobe bundle carried alongside the pixel pipeline
   typedef struct packed {
      logic fsync;
      logic vsync;
      logic hsync;
   } sync_t;

   // Chroma offset 2^(wd-1) for a component width of wd bits
   function automatic int unsigned offset_f(input int unsigned wd);
      return 32'd1 << (wd - 32'd1);
   endfunction

endpackage

// File: rtl/img_sync_delay.sv
// Fixed-depth delay line for the 3-bit frame/line/pixel strobe bus.
module img_sync_delay
   import img_ycbcr_pkg::*;
#(
   parameter int unsigned DEPTH = 3
) (
   input  logic       clk_i,
   input  logic       rst_ni,
   input  logic [2:0] sync_i,
   output logic [2:0] sync_o
);

   localparam int unsigned BUS_W  = 3;
   localparam int unsigned PIPE_W = BUS_W * DEPTH;

   logic [PIPE_W-1:0] pipe_q;
   logic [PIPE_W-1:0] pipe_d;

   // Shift the newest strobe sample into the low end of the chain
   if (DEPTH == 1) begin : g_one
      assign pipe_d = sync_i;
   end else begin : g_many
      assign pipe_d = {pipe_q[PIPE_W-BUS_W-1:0], sync_i};
   end

   // Delay chain registers
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         pipe_q <= '0;
      end else begin
         pipe_q <= pipe_d;
      end
   end

   assign sync_o = pipe_q[PIPE_W-1 -: BUS_W];

endmodule

// File: rtl/ycbcr444_to_rgb888.sv
// 3-stage full-range BT.601 YCbCr 4:4:4 to RGB converter with sync
// checking and sticky status flags.
module ycbcr444_to_rgb888
   import img_ycbcr_pkg::*;
#(
   parameter int unsigned MD_SIM_ABLE = 0,
   parameter int unsigned WD_IMG_DATA = 8,
   parameter int unsigned WD_ERR_INFO = 4
) (
   input  logic                   i_sys_clk,
   input  logic                   i_sys_resetn,
   input  logic                   s_img_ycbcr444_c_fsync,
   input  logic                   s_img_ycbcr444_c_vsync,
   input  logic                   s_img_ycbcr444_c_hsync,
   input  logic [WD_IMG_DATA-1:0] s_img_ycbcr444_y_mdat0,
   input  logic [WD_IMG_DATA-1:0] s_img_ycbcr444_b_mdat1,
   input  logic [WD_IMG_DATA-1:0] s_img_ycbcr444_r_mdat2,
   output logic                   m_img_rgb888_c_fsync,
   output logic                   m_img_rgb888_c_vsync,
   output logic                   m_img_rgb888_c_hsync,
   output logic [WD_IMG_DATA-1:0] m_img_rgb888_r_mdat0,
   output logic [WD_IMG_DATA-1:0] m_img_rgb888_g_mdat1,
   output logic [WD_IMG_DATA-1:0] m_img_rgb888_b_mdat2,
   output logic [WD_ERR_INFO-1:0] m_err_ycbcr444_info1
);

   localparam int unsigned WD_D    = WD_IMG_DATA + 1;
   localparam int unsigned WD_CALC = WD_IMG_DATA + 11;

   localparam logic signed [WD_D-1:0]    K_OFF   = WD_D'(offset_f(WD_IMG_DATA));
   localparam logic signed [WD_CALC-1:0] K_R_CR  = WD_CALC'(COEF_R_CR);
   localparam logic signed [WD_CALC-1:0] K_G_CB  = WD_CALC'(COEF_G_CB);
   localparam logic signed [WD_CALC-1:0] K_G_CR  = WD_CALC'(COEF_G_CR);
   localparam logic signed [WD_CALC-1:0] K_B_CB  = WD_CALC'(COEF_B_CB);
   localparam logic signed [WD_CALC-1:0] K_ROUND = WD_CALC'(ROUND_Q8);
   localparam logic signed [WD_CALC-1:0] K_MAX   =
      WD_CALC'((32'd1 << WD_IMG_DATA) - 32'd1);
   localparam logic [CNT_W-1:0]          CNT_MAX = '1;

   // Saturate to [0, 2^WD-1]; MSB of the result flags a clip
   function automatic logic [WD_IMG_DATA:0] clamp_f(input logic signed [WD_CALC-1:0] v);
      if (v[WD_CALC-1]) begin
         return {1'b1, {WD_IMG_DATA{1'b0}}};
      end else if (v > K_MAX) begin
         return {1'b1, {WD_IMG_DATA{1'b1}}};
      end
      return {1'b0, v[WD_IMG_DATA-1:0]};
   endfunction

   // Control state
   logic                   fsync_low_q, fsync_low_d;
   logic                   vsync_prev_q, vsync_prev_d;
   logic                   armed_q, armed_d;
   logic                   ref_pend_q, ref_pend_d;
   logic [CNT_W-1:0]       cnt_q, cnt_d;
   logic [CNT_W-1:0]       ref_q, ref_d;
   logic [ERR_W-1:0]       err_q, err_d;

   // Stage 1: offset-removed components
   logic                   v1_q, v1_d;
   logic [WD_IMG_DATA-1:0] y1_q, y1_d;
   logic signed [WD_D-1:0] cb1_q, cb1_d;
   logic signed [WD_D-1:0] cr1_q, cr1_d;

   // Stage 2: products
   logic                      v2_q, v2_d;
   logic [WD_IMG_DATA-1:0]    y2_q, y2_d;
   logic signed [WD_CALC-1:0] pr2_q, pr2_d;
   logic signed [WD_CALC-1:0] pgb2_q, pgb2_d;
   logic signed [WD_CALC-1:0] pgr2_q, pgr2_d;
   logic signed [WD_CALC-1:0] pb2_q, pb2_d;

   // Stage 3: output pixel
   logic [WD_IMG_DATA-1:0] r_q, r_d;
   logic [WD_IMG_DATA-1:0] g_q, g_d;
   logic [WD_IMG_DATA-1:0] b_q, b_d;

   // Combinational helpers
   logic                      fsync_rise_c, armed_c, vs_rise_c, vs_fall_c;
   logic                      clip_c;
   logic [ERR_W-1:0]          err_set_c;
   logic signed [WD_CALC-1:0] cb_ext_c, cr_ext_c, y_ext_c;
   logic signed [WD_CALC-1:0] r_full_c, g_full_c, b_full_c;
   logic [WD_IMG_DATA:0]      r_cl_c, g_cl_c, b_cl_c;
   sync_t                     sync_in_c;
   sync_t                     sync_out_c;

   // Frame arming, edge detection and strobe gating
   always_comb begin
      fsync_rise_c    = s_img_ycbcr444_c_fsync & fsync_low_q;
      armed_c         = armed_q | fsync_rise_c;
      vs_rise_c       = s_img_ycbcr444_c_vsync & ~vsync_prev_q;
      vs_fall_c       = ~s_img_ycbcr444_c_vsync & vsync_prev_q;
      sync_in_c.fsync = s_img_ycbcr444_c_fsync & armed_c;
      sync_in_c.vsync = s_img_ycbcr444_c_vsync & armed_c;
      sync_in_c.hsync = s_img_ycbcr444_c_hsync & armed_c;
   end

   // Datapath: offset removal, products, then round/shift/clamp
   always_comb begin
      v1_d  = sync_in_c.hsync;
      y1_d  = s_img_ycbcr444_y_mdat0;
      cb1_d = $signed({1'b0, s_img_ycbcr444_b_mdat1}) - K_OFF;
      cr1_d = $signed({1'b0, s_img_ycbcr444_r_mdat2}) - K_OFF;

      cb_ext_c = {{(WD_CALC-WD_D){cb1_q[WD_D-1]}}, cb1_q};
      cr_ext_c = {{(WD_CALC-WD_D){cr1_q[WD_D-1]}}, cr1_q};
      v2_d     = v1_q;
      y2_d     = y1_q;
      pr2_d    = cr_ext_c * K_R_CR;
      pgb2_d   = cb_ext_c * K_G_CB;
      pgr2_d   = cr_ext_c * K_G_CR;
      pb2_d    = cb_ext_c * K_B_CB;

      y_ext_c  = {{(WD_CALC-WD_IMG_DATA){1'b0}}, y2_q};
      r_full_c = y_ext_c + ((pr2_q + K_ROUND) >>> COEF_SHIFT);
      g_full_c = y_ext_c - ((pgb2_q + pgr2_q + K_ROUND) >>> COEF_SHIFT);
      b_full_c = y_ext_c + ((pb2_q + K_ROUND) >>> COEF_SHIFT);
      r_cl_c   = clamp_f(r_full_c);
      g_cl_c   = clamp_f(g_full_c);
      b_cl_c   = clamp_f(b_full_c);
      clip_c   = v2_q & (r_cl_c[WD_IMG_DATA] | g_cl_c[WD_IMG_DATA] | b_cl_c[WD_IMG_DATA]);
      r_d      = v2_q ? r_cl_c[WD_IMG_DATA-1:0] : '0;
      g_d      = v2_q ? g_cl_c[WD_IMG_DATA-1:0] : '0;
      b_d      = v2_q ? b_cl_c[WD_IMG_DATA-1:0] : '0;
   end

   // Line length tracking and sticky error flags
   always_comb begin
      fsync_low_d  = ~s_img_ycbcr444_c_fsync;
      vsync_prev_d = s_img_ycbcr444_c_vsync;
      armed_d      = armed_c;
      cnt_d        = cnt_q;
      ref_d        = ref_q;
      ref_pend_d   = ref_pend_q;
      err_set_c    = '0;

      if (vs_rise_c) begin
         cnt_d = s_img_ycbcr444_c_hsync ? CNT_W'(1) : '0;
      end else if (s_img_ycbcr444_c_vsync && s_img_ycbcr444_c_hsync && cnt_q != CNT_MAX) begin
         cnt_d = cnt_q + 1'b1;
      end

      // First line end after a frame start becomes the reference length
      if (fsync_rise_c) begin
         ref_pend_d = 1'b1;
      end else if (armed_q && vs_fall_c && ref_pend_q) begin
         ref_d      = cnt_q;
         ref_pend_d = 1'b0;
      end

      err_set_c[ERR_HS_NO_VS] = armed_c & s_img_ycbcr444_c_hsync & ~s_img_ycbcr444_c_vsync;
      err_set_c[ERR_VS_NO_FS] = armed_c & s_img_ycbcr444_c_vsync & ~s_img_ycbcr444_c_fsync;
      err_set_c[ERR_LINE_LEN] = armed_q & ~fsync_rise_c & vs_fall_c & ~ref_pend_q &
                                (cnt_q != ref_q);
      err_set_c[ERR_CLAMP]    = clip_c;

      // A set on the clearing cycle still leaves the bit high
      err_d = (fsync_rise_c ? '0 : err_q) | err_set_c;
   end

   // All state registers
   always_ff @(posedge i_sys_clk or negedge i_sys_resetn) begin
      if (!i_sys_resetn) begin
         fsync_low_q  <= 1'b0;
         vsync_prev_q <= 1'b0;
         armed_q      <= 1'b0;
         ref_pend_q   <= 1'b0;
         cnt_q        <= '0;
         ref_q        <= '0;
         err_q        <= '0;
         v1_q         <= 1'b0;
         y1_q         <= '0;
         cb1_q        <= '0;
         cr1_q        <= '0;
         v2_q         <= 1'b0;
         y2_q         <= '0;
         pr2_q        <= '0;
         pgb2_q       <= '0;
         pgr2_q       <= '0;
         pb2_q        <= '0;
         r_q          <= '0;
         g_q          <= '0;
         b_q          <= '0;
      end else begin
         fsync_low_q  <= fsync_low_d;
         vsync_prev_q <= vsync_prev_d;
         armed_q      <= armed_d;
         ref_pend_q   <= ref_pend_d;
         cnt_q        <= cnt_d;
         ref_q        <= ref_d;
         err_q        <= err_d;
         v1_q         <= v1_d;
         y1_q         <= y1_d;
         cb1_q        <= cb1_d;
         cr1_q        <= cr1_d;
         v2_q         <= v2_d;
         y2_q         <= y2_d;
         pr2_q        <= pr2_d;
         pgb2_q       <= pgb2_d;
         pgr2_q       <= pgr2_d;
         pb2_q        <= pb2_d;
         r_q          <= r_d;
         g_q          <= g_d;
         b_q          <= b_d;
      end
   end

   img_sync_delay #(
      .DEPTH (PIPE_LATENCY)
   ) u_sync_delay (
      .clk_i  (i_sys_clk),
      .rst_ni (i_sys_resetn),
      .sync_i (sync_in_c),
      .sync_o (sync_out_c)
   );

   assign m_img_rgb888_c_fsync = sync_out_c.fsync;
   assign m_img_rgb888_c_vsync = sync_out_c.vsync;
   assign m_img_rgb888_c_hsync = sync_out_c.hsync;
   assign m_img_rgb888_r_mdat0 = r_q;
   assign m_img_rgb888_g_mdat1 = g_q;
   assign m_img_rgb888_b_mdat2 = b_q;
   assign m_err_ycbcr444_info1 = WD_ERR_INFO'(err_q);

   // Report each status flag as it rises
   if (MD_SIM_ABLE != 0) begin : g_sim
      for (genvar gi = 0; gi < ERR_W; gi++) begin : g_bit
         always @(posedge i_sys_clk) begin
            if (i_sys_resetn && err_d[gi] && !err_q[gi]) begin
               $info("err[%0d] set, pixel count %0d", gi, cnt_q);
            end
         end
      end
   end

endmodule

// File: tb/tb_ycbcr444_to_rgb888.sv
// Directed bench for ycbcr444_to_rgb888: latency, conversion, clamping,
// line-length and sync errors, sticky clearing and mid-frame reset.
module tb_ycbcr444_to_rgb888;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       fs, vs, hs;
   logic [7:0] y, cb, cr;
   logic       fs_o, vs_o, hs_o;
   logic [7:0] r_o, g_o, b_o;
   logic [3:0] err_o;

   int tests = 0;
   int fails = 0;

   ycbcr444_to_rgb888 dut (
      .i_sys_clk              (clk),
      .i_sys_resetn           (rst_n),
      .s_img_ycbcr444_c_fsync (fs),
      .s_img_ycbcr444_c_vsync (vs),
      .s_img_ycbcr444_c_hsync (hs),
      .s_img_ycbcr444_y_mdat0 (y),
      .s_img_ycbcr444_b_mdat1 (cb),
      .s_img_ycbcr444_r_mdat2 (cr),
      .m_img_rgb888_c_fsync   (fs_o),
      .m_img_rgb888_c_vsync   (vs_o),
      .m_img_rgb888_c_hsync   (hs_o),
      .m_img_rgb888_r_mdat0   (r_o),
      .m_img_rgb888_g_mdat1   (g_o),
      .m_img_rgb888_b_mdat2   (b_o),
      .m_err_ycbcr444_info1   (err_o)
   );

   always #5 clk = ~clk;

   // Advance one clock and settle just past the rising edge
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic f, input logic v, input logic h,
                        input logic [7:0] yy, input logic [7:0] bb, input logic [7:0] rr);
      fs = f; vs = v; hs = h; y = yy; cb = bb; cr = rr;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   initial begin
      // Reset state
      rst_n = 1'b0;
      drive(0, 0, 0, 8'd0, 8'd0, 8'd0);
      tick(); tick();
      chk("rst_sync", {29'd0, fs_o, vs_o, hs_o}, 32'h0);
      chk("rst_rgb", {8'd0, r_o, g_o, b_o}, 32'h0);
      chk("rst_err", {28'd0, err_o}, 32'h0);
      rst_n = 1'b1;
      tick();

      // Frame start, line 0
      drive(1, 0, 0, 8'd0, 8'd0, 8'd0);       tick();
      drive(1, 1, 0, 8'd0, 8'd0, 8'd0);       tick();
      drive(1, 1, 1, 8'd128, 8'd128, 8'd128); tick();
      drive(1, 1, 0, 8'd0, 8'd0, 8'd0);       tick();
      chk("lat2_sync", {29'd0, fs_o, vs_o, hs_o}, 32'h6);
      chk("lat2_rgb", {8'd0, r_o, g_o, b_o}, 32'h0);
      tick();
      chk("grey_hs", {31'd0, hs_o}, 32'h1);
      chk("grey_rgb", {8'd0, r_o, g_o, b_o}, 32'h808080);
      chk("grey_err", {28'd0, err_o}, 32'h0);
      tick();
      chk("idle_hs", {31'd0, hs_o}, 32'h0);
      chk("idle_rgb", {8'd0, r_o, g_o, b_o}, 32'h0);

      // Red-heavy pixel clamps R
      drive(1, 1, 1, 8'd255, 8'd128, 8'd255); tick();
      drive(1, 1, 0, 8'd0, 8'd0, 8'd0);       tick();
      chk("clip_pre_err", {28'd0, err_o}, 32'h0);
      tick();
      chk("clip_rgb", {8'd0, r_o, g_o, b_o}, 32'hffa4ff);
      chk("clip_err", {28'd0, err_o}, 32'h8);

      // Back-to-back pixels: black-ish (clamps R,B) then a mid colour
      drive(1, 1, 1, 8'd0, 8'd0, 8'd0);       tick();
      drive(1, 1, 1, 8'd100, 8'd150, 8'd90);  tick();
      drive(1, 1, 0, 8'd0, 8'd0, 8'd0);       tick();
      chk("zero_hs", {31'd0, hs_o}, 32'h1);
      chk("zero_rgb", {8'd0, r_o, g_o, b_o}, 32'h008700);
      tick();
      chk("mid_hs", {31'd0, hs_o}, 32'h1);
      chk("mid_rgb", {8'd0, r_o, g_o, b_o}, 32'h2f788b);

      // Line 0 ends with 4 pixels (reference), line 1 matches
      drive(1, 0, 0, 8'd0, 8'd0, 8'd0); tick();
      drive(1, 1, 0, 8'd0, 8'd0, 8'd0); tick();
      for (int i = 0; i < 4; i++) begin
         drive(1, 1, 1, 8'd128, 8'd128, 8'd128); tick();
      end
      drive(1, 0, 0, 8'd0, 8'd0, 8'd0); tick();
      tick();
      chk("len_ok", {28'd0, err_o}, 32'h8);

      // Line 2 is one pixel short
      drive(1, 1, 0, 8'd0, 8'd0, 8'd0); tick();
      for (int i = 0; i < 3; i++) begin
         drive(1, 1, 1, 8'd128, 8'd128, 8'd128); tick();
      end
      chk("len_pre", {28'd0, err_o}, 32'h8);
      drive(1, 0, 0, 8'd0, 8'd0, 8'd0); tick();
      chk("len_short", {28'd0, err_o}, 32'hc);

      // New frame clears all flags
      drive(0, 0, 0, 8'd0, 8'd0, 8'd0); tick();
      drive(1, 0, 0, 8'd0, 8'd0, 8'd0); tick();
      chk("fsync_clr", {28'd0, err_o}, 32'h0);

      // hsync outside vsync, then vsync outside fsync
      drive(1, 0, 1, 8'd128, 8'd128, 8'd128); tick();
      drive(1, 0, 0, 8'd0, 8'd0, 8'd0);       tick();
      chk("err_hs", {28'd0, err_o}, 32'h1);
      drive(0, 1, 0, 8'd0, 8'd0, 8'd0); tick();
      drive(0, 0, 0, 8'd0, 8'd0, 8'd0); tick();
      chk("err_vs", {28'd0, err_o}, 32'h3);

      // Set condition on the clearing cycle keeps that bit
      drive(1, 0, 1, 8'd128, 8'd128, 8'd128); tick();
      chk("clr_set", {28'd0, err_o}, 32'h1);
      drive(1, 0, 0, 8'd0, 8'd0, 8'd0); tick();

      // Reset mid-line with a clamping pixel in flight
      drive(1, 1, 0, 8'd0, 8'd0, 8'd0);       tick();
      drive(1, 1, 1, 8'd255, 8'd128, 8'd255); tick();
      tick();
      rst_n = 1'b0;
      #1;
      chk("mrst_sync", {29'd0, fs_o, vs_o, hs_o}, 32'h0);
      chk("mrst_rgb", {8'd0, r_o, g_o, b_o}, 32'h0);
      chk("mrst_err", {28'd0, err_o}, 32'h0);
      tick();
      chk("mrst_hold", {5'd0, fs_o, vs_o, hs_o, r_o, g_o, b_o}, 32'h0);
      rst_n = 1'b1;
      for (int i = 0; i < 5; i++) begin
         tick();
         chk("post_rst_quiet", {4'd0, err_o, fs_o, vs_o, hs_o, 1'b0, r_o, g_o, b_o}, 32'h0);
      end
      drive(1, 0, 0, 8'd0, 8'd0, 8'd0); tick();
      chk("post_rst_err", {28'd0, err_o}, 32'h0);

      // Fresh frame converts again
      drive(0, 0, 0, 8'd0, 8'd0, 8'd0);      tick();
      drive(1, 0, 0, 8'd0, 8'd0, 8'd0);      tick();
      drive(1, 1, 0, 8'd0, 8'd0, 8'd0);      tick();
      drive(1, 1, 1, 8'd100, 8'd150, 8'd90); tick();
      drive(1, 1, 0, 8'd0, 8'd0, 8'd0);      tick();
      chk("rearm_lat2", {31'd0, hs_o}, 32'h0);
      tick();
      chk("rearm_hs", {31'd0, hs_o}, 32'h1);
      chk("rearm_rgb", {8'd0, r_o, g_o, b_o}, 32'h2f788b);
      drive(1, 0, 0, 8'd0, 8'd0, 8'd0); tick();
      drive(0, 0, 0, 8'd0, 8'd0, 8'd0); tick();
      chk("final_err", {28'd0, err_o}, 32'h0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/ycbcr444_to_rgb888.md
YCBCR444_TO_RGB888 -- requirements
Module: ycbcr444_to_rgb888

Interface
REQ-001 MD_SIM_ABLE, 0, simulation-only checks enabled when 1; no effect on synthesized datapath.
REQ-002 WD_IMG_DATA, 8, component width; all arithmetic below is stated for 8 and SHALL scale with offset 2^(WD_IMG_DATA-1).
REQ-003 WD_ERR_INFO, 4, width of error info bus.
REQ-004 i_sys_clk  in  1  single clock; all logic on rising edge.
REQ-005 i_sys_resetn  in  1  asynchronous, active-low reset.
REQ-006 s_img_ycbcr444_c_fsync / c_vsync / c_hsync  in  1 each  frame, line, pixel-valid strobes.
REQ-007 s_img_ycbcr444_y_mdat0 / b_mdat1 / r_mdat2  in  WD_IMG_DATA each  Y, Cb, Cr.
REQ-008 m_img_rgb888_c_fsync / c_vsync / c_hsync  out  1 each  strobes delayed by pipeline latency.
REQ-009 m_img_rgb888_r_mdat0 / g_mdat1 / b_mdat2  out  WD_IMG_DATA each  R, G, B.
REQ-010 m_err_ycbcr444_info1  out  WD_ERR_INFO  sticky status flags.

Function
REQ-011 Conversion SHALL be full-range BT.601 inverse, Q8 coefficients: R = Y + ((359*(Cr-128) + 128) >>> 8); G = Y - ((88*(Cb-128) + 183*(Cr-128) + 128) >>> 8); B = Y + ((454*(Cb-128) + 128) >>> 8); >>> is arithmetic (floor).
REQ-012 Intermediates SHALL be signed, at least WD_IMG_DATA+11 bits; no overflow before clamp.
REQ-013 Each result SHALL saturate to [0, 255].
REQ-014 Pipeline SHALL be exactly 3 cycles: S1 register inputs and subtract 128 offsets; S2 register the four products; S3 sum, round, shift, clamp into output registers.
REQ-015 All three sync strobes SHALL be delayed by the same 3 cycles, so input pixel at cycle n appears with m_..._c_hsync at cycle n+3.
REQ-016 Output data SHALL be 0 on any cycle where m_img_rgb888_c_hsync is 0.
REQ-017 Pipeline SHALL accept one pixel per cycle with no stall; back-to-back hsync supported.
REQ-018 Pixel counter SHALL count input hsync pulses within a vsync-high period and reset to 0 on vsync rising edge.
REQ-019 On the first vsync falling edge after fsync rises, the count SHALL be stored as reference line length.
REQ-020 err[0] SHALL set when input hsync=1 while vsync=0.
REQ-021 err[1] SHALL set when input vsync=1 while fsync=0.
REQ-022 err[2] SHALL set at a vsync falling edge whose count differs from the stored line length.
REQ-023 err[3] SHALL set when any channel clamps (result <0 or >255) on a valid pixel.
REQ-024 All err bits SHALL be sticky and cleared only on input fsync rising edge or reset; a simultaneous set condition on the clearing cycle wins (bit stays 1).
REQ-025 Pixel counter SHALL saturate at its maximum (16 bits) instead of wrapping.
REQ-026 When MD_SIM_ABLE=1, an err bit rising SHALL $display its index and pixel count.

Reset
REQ-027 While i_sys_resetn=0, all pipeline registers, strobes, data outputs, counters, reference line length and err bits SHALL be 0.
REQ-028 Reset asserted mid-frame SHALL abort the frame; after release, outputs stay 0 until a new input fsync rising edge, and partial-line data SHALL NOT be emitted.

Structure
REQ-029 Coefficients (359, 88, 183, 454), offset 128, rounding constant 128, latency 3 and err bit indices SHALL live in shared package img_ycbcr_pkg.
REQ-030 Sync delay SHALL be the sub-module img_sync_delay (parameter depth, 3-bit bus, async active-low reset); datapath stays in the top module.

Verification
REQ-031 Y=128,Cb=128,Cr=128 with hsync -> R=128,G=128,B=128 exactly 3 cycles later, err=0.
REQ-032 Y=255,Cb=128,Cr=255 -> R=255,G=164,B=255, err[3]=1 from the output cycle on.
REQ-033 Y=0,Cb=0,Cr=0 -> R=0,G=135,B=0, err[3]=1.
REQ-034 960x640 frame from ./data/ycbcr.dat through this block -> every pixel within +/-2 of ./data/rgb.dat per channel, sync strobes identical to input shifted by 3, err=0.
REQ-035 Line 0 with 960 hsync, line 1 with 959 -> err[2]=1 the cycle after line-1 vsync falls; next fsync rise clears it.
REQ-036 Reset pulsed at pixel 500 of line 10 -> all outputs 0 during reset; no hsync output until after next fsync; next full frame converts correctly.
